alu_toggle_monitor: RTL and testbench
=====================================

# alu_toggle_monitor

Downstream observer for the 16-bit ALUs (ripple and CLA variants). It samples every valid ALU result together with its operands and opcode, and computes output toggle count and operand Hamming weights in hardware. It accumulates per-opcode activity statistics over a programmable sample window, then streams one record per opcode over a valid/ready port. This replaces offline CSV post-processing for on-chip switching-activity comparison between ALU implementations.

## Interface
Parameters:
- WIDTH, 16, ALU datapath width (a, b, yout).
- SAMPLE_W, 16, width of window length and per-opcode sample counters.
- SUM_W, 32, width of per-opcode toggle and Hamming-weight accumulators.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU sample present this cycle.
- in_op  in  4  ALU opcode s for the sample.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_y  in  WIDTH  ALU result yout.
- start  in  1  begin a collection window; honoured only in IDLE.
- window_len  in  SAMPLE_W  samples per window; latched on accepted start.
- busy  out  1  high in COLLECT or DUMP.
- done  out  1  one-cycle pulse after the last record is accepted.
- rd_valid  out  1  record available.
- rd_ready  in  1  consumer accepts record.
- rd_op  out  4  opcode of current record.
- rd_count  out  SAMPLE_W  samples seen for rd_op.
- rd_toggle_sum  out  SUM_W  sum of toggles for rd_op.
- rd_max_toggle  out  5  maximum single-sample toggle count for rd_op.
- rd_hw_sum  out  SUM_W  sum of popcount(a)+popcount(b) for rd_op.

## Operation
- Toggle count T = popcount(in_y ^ prev_y), range 0..16. HW = popcount(in_a) + popcount(in_b), range 0..32.
- prev_y updates to in_y on every in_valid cycle in every state, including IDLE and DUMP. Reset value is 0, so the first sample after reset compares against 0.
- Per-opcode register file of 16 entries, each holding count, toggle_sum, max_toggle and hw_sum.
- FSM states are IDLE, COLLECT and DUMP.
- IDLE: start=1 latches window_len, zeroes all 16 entries and the sample counter, and moves to COLLECT, or to DUMP if window_len==0. Samples in the start cycle are not accumulated.
- COLLECT: on each in_valid, entry[in_op] is updated as follows:
  - count += 1
  - toggle_sum += T
  - hw_sum += HW
  - max_toggle = max(max_toggle, T)
  - the sample counter increments.
- COLLECT exits: on the edge accepting sample number window_len, the FSM moves to DUMP.
- Saturation: count, toggle_sum and hw_sum saturate at all-ones and never wrap.
- DUMP: rd_op starts at 0. The current record is presented with rd_valid=1 and advances on rd_valid && rd_ready. On acceptance of op 15 the FSM returns to IDLE and done pulses.
- DUMP ignores in_valid for accumulation; prev_y still tracks.
- start outside IDLE is ignored and window_len is not re-latched.
- Reset at any time: return to IDLE immediately and zero all entries and prev_y.

## Timing
- Reset values: busy=0, done=0, rd_valid=0, rd_op=0, rd_count=0, rd_toggle_sum=0, rd_max_toggle=0, rd_hw_sum=0.
- Accumulation latency is 1 cycle: a sample at edge t is reflected in entry state after edge t.
- The first rd_valid is asserted the cycle after the final window sample's edge (or after the start edge if window_len==0).
- Record fields are stable while rd_valid && !rd_ready. A new record appears the cycle after acceptance with no bubble, and rd_valid may remain continuously high.
- done is high for exactly one cycle, the cycle after op 15 is accepted, with busy=0 in that same cycle. A start in that cycle is accepted.
- Throughput: one sample per cycle in COLLECT. Back-to-back in_valid samples with the same or differing ops require no stalls.

## Test plan
- Reset, then start with window_len=4. Send op=3 samples with y = 0x0000, 0xFFFF, 0xFFFF, 0x00FF, all a=b=0x0001 -> op3 record reads count=4, toggle_sum=0+16+0+8=24, max=16, hw_sum=8. All other ops read 0, and done pulses after op 15 is accepted.
- prev_y tracking across states: in IDLE send y=0x000F, then start with window_len=1 and send op=0, y=0x00F0 -> op0 toggle_sum=8, not 4.
- Backpressure: hold rd_ready=0 for 5 cycles at op 2 -> rd_op stays 2 and fields are stable. Then toggle rd_ready every cycle -> 16 records delivered in order 0..15.
- window_len=0 -> DUMP entered directly and 16 all-zero records are emitted. start asserted during COLLECT is ignored (window length unchanged).
- Saturation: with SAMPLE_W=4, window_len=15, send 15 samples of op 7 -> count=15, with no wrap and no extra records.
- Assert rst_n low mid-DUMP at op 9 -> busy=0 and rd_valid=0 asynchronously. A fresh window after reset reports only new samples, with prev_y=0.

Source files
------------

// File: rtl/alu_toggle_monitor.sv
// alu_toggle_monitor: observes ALU results, computes output toggle count and
// operand Hamming weight per sample, accumulates per-opcode statistics over a
// programmable window and then streams one record per opcode.
//
// Handshake: a record transfers on a cycle where rd_valid && rd_ready at the
// rising edge; while rd_valid && !rd_ready the record fields hold steady, and
// the next record is presented the cycle after acceptance with no bubble.
module alu_toggle_monitor #(
   parameter int WIDTH    = 16,
   parameter int SAMPLE_W = 16,
   parameter int SUM_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [3:0]          in_op,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   input  logic [WIDTH-1:0]    in_y,
   input  logic                start,
   input  logic [SAMPLE_W-1:0] window_len,
   output logic                busy,
   output logic                done,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [3:0]          rd_op,
   output logic [SAMPLE_W-1:0] rd_count,
   output logic [SUM_W-1:0]    rd_toggle_sum,
   output logic [4:0]          rd_max_toggle,
   output logic [SUM_W-1:0]    rd_hw_sum
);

   localparam int TW  = $clog2(WIDTH + 1);
   localparam int HWW = $clog2(2 * WIDTH + 1);
   localparam logic [SAMPLE_W-1:0] ONE_S = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DUMP
   } state_t;

   state_t              state;
   logic [WIDTH-1:0]    prev_y;
   logic [SAMPLE_W-1:0] win_len;
   logic [SAMPLE_W-1:0] sample_cnt;

   logic [SAMPLE_W-1:0] cnt_mem [16];
   logic [SUM_W-1:0]    tog_mem [16];
   logic [SUM_W-1:0]    hw_mem  [16];
   logic [TW-1:0]       max_mem [16];

   logic [TW-1:0]       toggle;
   logic [HWW-1:0]      hweight;
   logic [SUM_W:0]      tog_wide;
   logic [SUM_W:0]      hw_wide;
   logic [SUM_W-1:0]    tog_next;
   logic [SUM_W-1:0]    hw_next;
   logic [SAMPLE_W-1:0] cnt_next;
   logic [TW-1:0]       max_next;

   function automatic logic [HWW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [HWW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) c = c + HWW'(v[i]);
      return c;
   endfunction

   // Per-sample metrics and saturating next values for the addressed entry
   always_comb begin
      toggle   = TW'(popcount(in_y ^ prev_y));
      hweight  = popcount(in_a) + popcount(in_b);
      tog_wide = {1'b0, tog_mem[in_op]} + (SUM_W + 1)'(toggle);
      hw_wide  = {1'b0, hw_mem[in_op]} + (SUM_W + 1)'(hweight);
      tog_next = tog_wide[SUM_W] ? '1 : tog_wide[SUM_W-1:0];
      hw_next  = hw_wide[SUM_W] ? '1 : hw_wide[SUM_W-1:0];
      cnt_next = (cnt_mem[in_op] == '1) ? '1 : cnt_mem[in_op] + ONE_S;
      max_next = (toggle > max_mem[in_op]) ? toggle : max_mem[in_op];
   end

   // Control FSM, previous-result tracking and per-opcode register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         prev_y     <= '0;
         win_len    <= '0;
         sample_cnt <= '0;
         rd_op      <= '0;
         done       <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            cnt_mem[i] <= '0;
            tog_mem[i] <= '0;
            hw_mem[i]  <= '0;
            max_mem[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         // Previous result follows every valid sample regardless of state
         if (in_valid) prev_y <= in_y;
         case (state)
            S_IDLE: begin
               if (start) begin
                  win_len    <= window_len;
                  sample_cnt <= '0;
                  rd_op      <= '0;
                  for (int i = 0; i < 16; i++) begin
                     cnt_mem[i] <= '0;
                     tog_mem[i] <= '0;
                     hw_mem[i]  <= '0;
                     max_mem[i] <= '0;
                  end
                  state <= (window_len == '0) ? S_DUMP : S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (in_valid) begin
                  cnt_mem[in_op] <= cnt_next;
                  tog_mem[in_op] <= tog_next;
                  hw_mem[in_op]  <= hw_next;
                  max_mem[in_op] <= max_next;
                  sample_cnt     <= sample_cnt + ONE_S;
                  if (sample_cnt == win_len - ONE_S) state <= S_DUMP;
               end
            end
            S_DUMP: begin
               if (rd_ready) begin
                  if (rd_op == 4'd15) begin
                     rd_op <= '0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     rd_op <= rd_op + 4'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy          = (state != S_IDLE);
   assign rd_valid      = (state == S_DUMP);
   assign rd_count      = cnt_mem[rd_op];
   assign rd_toggle_sum = tog_mem[rd_op];
   assign rd_hw_sum     = hw_mem[rd_op];
   assign rd_max_toggle = 5'(max_mem[rd_op]);

endmodule

// File: tb/tb_alu_toggle_monitor.sv
// Directed testbench for alu_toggle_monitor with hand-computed expectations.
module tb_alu_toggle_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  in_op;
   logic [15:0] in_a, in_b, in_y;
   logic        start;
   logic [15:0] window_len;
   logic        busy, done, rd_valid, rd_ready;
   logic [3:0]  rd_op;
   logic [15:0] rd_count;
   logic [31:0] rd_toggle_sum, rd_hw_sum;
   logic [4:0]  rd_max_toggle;

   // second instance with narrow sample counters
   logic        start2;
   logic [3:0]  window_len2;
   logic        busy2, done2, rd_valid2, rd_ready2;
   logic [3:0]  rd_op2;
   logic [3:0]  rd_count2;
   logic [31:0] rd_toggle_sum2, rd_hw_sum2;
   logic [4:0]  rd_max_toggle2;

   int checks = 0;
   int errors = 0;
   int e_cnt [16];
   int e_tog [16];
   int e_max [16];
   int e_hw  [16];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   alu_toggle_monitor u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_y(in_y), .start(start),
      .window_len(window_len), .busy(busy), .done(done),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_op(rd_op),
      .rd_count(rd_count), .rd_toggle_sum(rd_toggle_sum),
      .rd_max_toggle(rd_max_toggle), .rd_hw_sum(rd_hw_sum)
   );

   alu_toggle_monitor #(.SAMPLE_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_y(in_y), .start(start2),
      .window_len(window_len2), .busy(busy2), .done(done2),
      .rd_valid(rd_valid2), .rd_ready(rd_ready2), .rd_op(rd_op2),
      .rd_count(rd_count2), .rd_toggle_sum(rd_toggle_sum2),
      .rd_max_toggle(rd_max_toggle2), .rd_hw_sum(rd_hw_sum2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 16; i++) begin
         e_cnt[i] = 0; e_tog[i] = 0; e_max[i] = 0; e_hw[i] = 0;
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] y);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_y = y;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] len);
      start = 1'b1; window_len = len;
      tick();
      start = 1'b0;
   endtask

   // Drain all 16 records, optionally stalling at one op and/or toggling ready
   task automatic dump_check(input int stall_op, input bit toggle_rdy);
      for (int op = 0; op < 16; op++) begin
         check("rd_valid", rd_valid, 1);
         check("rd_op", rd_op, op);
         check("rd_count", rd_count, e_cnt[op]);
         check("rd_toggle_sum", rd_toggle_sum, e_tog[op]);
         check("rd_max_toggle", rd_max_toggle, e_max[op]);
         check("rd_hw_sum", rd_hw_sum, e_hw[op]);
         if (op == stall_op) begin
            rd_ready = 1'b0;
            repeat (5) begin
               tick();
               check("stall_op", rd_op, op);
               check("stall_count", rd_count, e_cnt[op]);
               check("stall_toggle", rd_toggle_sum, e_tog[op]);
               check("stall_hw", rd_hw_sum, e_hw[op]);
            end
         end
         if (toggle_rdy) begin
            rd_ready = 1'b0;
            tick();
            check("hold_op", rd_op, op);
         end
         rd_ready = 1'b1;
         tick();
      end
      rd_ready = 1'b0;
      check("done_pulse", done, 1);
      check("busy_at_done", busy, 0);
      check("rd_valid_at_done", rd_valid, 0);
      tick();
      check("done_one_cycle", done, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_y = '0;
      start = 1'b0; window_len = '0; rd_ready = 1'b0;
      start2 = 1'b0; window_len2 = '0; rd_ready2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_op", rd_op, 0);
      check("rst_rd_count", rd_count, 0);
      check("rst_rd_toggle", rd_toggle_sum, 0);
      check("rst_rd_max", rd_max_toggle, 0);
      check("rst_rd_hw", rd_hw_sum, 0);
      rst_n = 1'b1;
      tick();

      // basic window of four op3 samples
      do_start(16'd4);
      check("busy_collect", busy, 1);
      check("no_rec_collect", rd_valid, 0);
      send(4'd3, 16'h0001, 16'h0001, 16'h0000);
      send(4'd3, 16'h0001, 16'h0001, 16'hFFFF);
      send(4'd3, 16'h0001, 16'h0001, 16'hFFFF);
      send(4'd3, 16'h0001, 16'h0001, 16'h00FF);
      clear_exp();
      e_cnt[3] = 4; e_tog[3] = 24; e_max[3] = 16; e_hw[3] = 8;
      dump_check(-1, 1'b0);

      // prev_y keeps tracking while idle
      send(4'd5, 16'h0000, 16'h0000, 16'h000F);
      do_start(16'd1);
      send(4'd0, 16'h0000, 16'h0000, 16'h00F0);
      clear_exp();
      e_cnt[0] = 1; e_tog[0] = 8; e_max[0] = 8; e_hw[0] = 0;
      dump_check(-1, 1'b0);

      // backpressure: stall at op 2, then toggle ready each cycle
      do_start(16'd2);
      send(4'd2, 16'h0003, 16'h0000, 16'h0F0F);
      send(4'd9, 16'hFFFF, 16'hFFFF, 16'h0F0F);
      clear_exp();
      e_cnt[2] = 1; e_tog[2] = 12; e_max[2] = 12; e_hw[2] = 2;
      e_cnt[9] = 1; e_tog[9] = 0;  e_max[9] = 0;  e_hw[9] = 32;
      dump_check(2, 1'b1);

      // start during collect is ignored
      do_start(16'd3);
      send(4'd1, 16'h8000, 16'h0000, 16'h0F0E);
      start = 1'b1; window_len = 16'd1;
      send(4'd1, 16'h8000, 16'h0000, 16'h0F0F);
      start = 1'b0;
      check("start_ignored_busy", busy, 1);
      check("start_ignored_no_rec", rd_valid, 0);
      send(4'd1, 16'h8000, 16'h0000, 16'h0F0F);
      clear_exp();
      e_cnt[1] = 3; e_tog[1] = 2; e_max[1] = 1; e_hw[1] = 3;
      dump_check(-1, 1'b0);

      // zero-length window goes straight to dump
      do_start(16'd0);
      check("zero_win_valid", rd_valid, 1);
      clear_exp();
      dump_check(-1, 1'b0);

      // narrow-counter instance: full 15-sample window of op 7
      start2 = 1'b1; window_len2 = 4'd15;
      tick();
      start2 = 1'b0;
      for (int i = 0; i < 15; i++)
         send(4'd7, 16'h0001, 16'h0000, (i % 2 == 0) ? 16'h0F0E : 16'h0F0F);
      check("busy2_dump", rd_valid2, 1);
      for (int op = 0; op < 16; op++) begin
         check("rd_op2", rd_op2, op);
         check("rd_count2", rd_count2, (op == 7) ? 15 : 0);
         check("rd_toggle2", rd_toggle_sum2, (op == 7) ? 15 : 0);
         check("rd_hw2", rd_hw_sum2, (op == 7) ? 15 : 0);
         rd_ready2 = 1'b1;
         tick();
      end
      rd_ready2 = 1'b0;
      check("done2", done2, 1);
      tick();
      check("no_extra_rec2", rd_valid2, 0);
      check("busy_dut1_idle", busy, 0);

      // asynchronous reset in the middle of a dump
      do_start(16'd1);
      send(4'd4, 16'h0000, 16'h0000, 16'h1234);
      rd_ready = 1'b1;
      repeat (9) tick();
      check("mid_dump_op", rd_op, 9);
      rd_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_rd_valid", rd_valid, 0);
      check("async_rd_op", rd_op, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_start(16'd1);
      send(4'd6, 16'h0003, 16'h0001, 16'h0003);
      clear_exp();
      e_cnt[6] = 1; e_tog[6] = 2; e_max[6] = 2; e_hw[6] = 3;
      dump_check(-1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
